// File: rtl/pwm_led_array_if.sv
// Configuration write bus for pwm_led_array.
// master drives wr_en/wr_chan/wr_mode/wr_level; slave receives them.
interface pwm_led_array_if #(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic [3:0]       wr_chan;
   logic [1:0]       wr_mode;
   logic [WIDTH-1:0] wr_level;

   modport master (
      output wr_en, wr_chan, wr_mode, wr_level
   );

   modport slave (
      input wr_en, wr_chan, wr_mode, wr_level
   );
endinterface

// File: rtl/pwm_led_array.sv
// Multi-channel LED PWM driver with fixed, breathe, on and off modes.
// Ports: clk_50, rst_n, wr (config bus), led[CHANNELS], period_start.
module pwm_led_array #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 2500,
   parameter int STEP_DIV = 100000
) (
   input  logic                clk_50,
   input  logic                rst_n,
   pwm_led_array_if.slave      wr,
   output logic [CHANNELS-1:0] led,
   output logic                period_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [WIDTH-1:0] MAX = '1;

   typedef enum logic [1:0] {
      M_OFF = 2'b00,
      M_FIX = 2'b01,
      M_BRE = 2'b10,
      M_ON  = 2'b11
   } mode_e;

   logic [PW-1:0]       presc_q, presc_d;
   logic [WIDTH-1:0]    pos_q, pos_d;
   logic [SW-1:0]       stc_q, stc_d;
   logic [CHANNELS-1:0] led_q, led_d;
   logic                ps_q, ps_d;
   logic [CHANNELS-1:0] dir_q, dir_d;
   mode_e               mode_q   [CHANNELS];
   mode_e               mode_d   [CHANNELS];
   mode_e               mode_s_q [CHANNELS];
   mode_e               mode_s_d [CHANNELS];
   logic [WIDTH-1:0]    level_q  [CHANNELS];
   logic [WIDTH-1:0]    level_d  [CHANNELS];
   logic [WIDTH-1:0]    duty_s_q [CHANNELS];
   logic [WIDTH-1:0]    duty_s_d [CHANNELS];

   logic tick, stp, wrap;

   always_comb begin
      tick    = (presc_q == PW'(PRESCALE - 1));
      stp     = (stc_q == SW'(STEP_DIV - 1));
      wrap    = tick && (pos_q == MAX);
      presc_d = tick ? '0 : presc_q + 1'b1;
      pos_d   = tick ? pos_q + 1'b1 : pos_q;
      stc_d   = stp ? '0 : stc_q + 1'b1;
      ps_d    = wrap;
      led_d   = led_q;
      dir_d   = dir_q;
      for (int i = 0; i < CHANNELS; i++) begin
         mode_d[i]   = mode_q[i];
         level_d[i]  = level_q[i];
         mode_s_d[i] = mode_s_q[i];
         duty_s_d[i] = duty_s_q[i];
         // led samples the shadows of the period that is ending
         if (tick) begin
            unique case (mode_s_q[i])
               M_OFF:   led_d[i] = 1'b0;
               M_ON:    led_d[i] = 1'b1;
               default: led_d[i] = (pos_q < duty_s_q[i]);
            endcase
         end
         if (wrap) begin
            mode_s_d[i] = mode_q[i];
            duty_s_d[i] = level_q[i];
         end
         // a host write overrides a coincident breathe step
         if (wr.wr_en && (wr.wr_chan == 4'(i))) begin
            mode_d[i]  = mode_e'(wr.wr_mode);
            level_d[i] = wr.wr_level;
            dir_d[i]   = 1'b0;
         end else if (stp && (mode_q[i] == M_BRE)) begin
            if (!dir_q[i]) begin
               if (level_q[i] == MAX) dir_d[i] = 1'b1;
               else level_d[i] = level_q[i] + 1'b1;
            end else begin
               if (level_q[i] == '0) dir_d[i] = 1'b0;
               else level_d[i] = level_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         pos_q   <= '0;
         stc_q   <= '0;
         led_q   <= '0;
         ps_q    <= 1'b0;
         dir_q   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]   <= M_OFF;
            level_q[i]  <= '0;
            mode_s_q[i] <= M_OFF;
            duty_s_q[i] <= '0;
         end
      end else begin
         presc_q <= presc_d;
         pos_q   <= pos_d;
         stc_q   <= stc_d;
         led_q   <= led_d;
         ps_q    <= ps_d;
         dir_q   <= dir_d;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]   <= mode_d[i];
            level_q[i]  <= level_d[i];
            mode_s_q[i] <= mode_s_d[i];
            duty_s_q[i] <= duty_s_d[i];
         end
      end
   end

   assign led          = led_q;
   assign period_start = ps_q;

endmodule
